// File: rtl/branch_target_predictor_if.sv
// Fetch/execute side bundle of the branch target predictor:
// lookup request, registered prediction, resolved-branch update, flush.
interface branch_target_predictor_if #(
    parameter int PC_W = 64
);
    logic            lookup_en;
    logic [PC_W-1:0] lookup_pc;
    logic            pred_valid;
    logic            pred_hit;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            update_en;
    logic [PC_W-1:0] update_pc;
    logic            update_taken;
    logic [PC_W-1:0] update_target;
    logic            flush;

    modport master (
        output lookup_en, lookup_pc,
        output update_en, update_pc, update_taken, update_target,
        output flush,
        input  pred_valid, pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  lookup_en, lookup_pc,
        input  update_en, update_pc, update_taken, update_target,
        input  flush,
        output pred_valid, pred_hit, pred_taken, pred_target
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Tagged BTB with 2-bit saturating direction counters, registered lookup.
// Define BTB_TAG_CHECK_EN for tag storage/compare; otherwise hit = valid.
module branch_target_predictor #(
    parameter int INDEX_BITS = 5,
    parameter int PC_W       = 64
) (
    input  logic clk,
    input  logic arst_n,
    branch_target_predictor_if.slave bus
);
    localparam int DEPTH = 1 << INDEX_BITS;
    localparam int TAG_W = PC_W - INDEX_BITS - 2;

    logic [DEPTH-1:0] r_valid;
    logic [1:0]       r_ctr    [DEPTH];
    logic [PC_W-1:0]  r_target [DEPTH];

    logic            r_pred_valid;
    logic            r_pred_hit;
    logic            r_pred_taken;
    logic [PC_W-1:0] r_pred_target;

    logic [INDEX_BITS-1:0] w_l_idx;
    logic [INDEX_BITS-1:0] w_u_idx;
    logic                  w_l_hit;
    logic                  w_u_hit;
    logic                  w_l_taken;
    logic [PC_W-1:0]       w_l_next;
    logic                  w_unused;

    assign w_l_idx = bus.lookup_pc[INDEX_BITS+1:2];
    assign w_u_idx = bus.update_pc[INDEX_BITS+1:2];

`ifdef BTB_TAG_CHECK_EN
    logic [TAG_W-1:0] r_tag [DEPTH];

    assign w_l_hit = r_valid[w_l_idx] &&
        (r_tag[w_l_idx] == bus.lookup_pc[PC_W-1:INDEX_BITS+2]);
    assign w_u_hit = r_valid[w_u_idx] &&
        (r_tag[w_u_idx] == bus.update_pc[PC_W-1:INDEX_BITS+2]);

    always_ff @(posedge clk) begin
        if (!bus.flush && bus.update_en && bus.update_taken) begin
            r_tag[w_u_idx] <= bus.update_pc[PC_W-1:INDEX_BITS+2];
        end
    end

    assign w_unused = ^bus.update_pc[1:0];
`else
    // Aliased PCs share an entry: only the valid bit decides a hit.
    assign w_l_hit = r_valid[w_l_idx];
    assign w_u_hit = r_valid[w_u_idx];

    assign w_unused = ^{bus.update_pc[PC_W-1:INDEX_BITS+2],
                        bus.update_pc[1:0]};
`endif

    assign w_l_taken = w_l_hit && r_ctr[w_l_idx][1];
    assign w_l_next  = w_l_taken ? r_target[w_l_idx]
                                 : bus.lookup_pc + PC_W'(4);

    // Flush beats a same-cycle update; lookups read pre-edge state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else if (bus.flush) begin
            r_valid <= '0;
        end else if (bus.update_en) begin
            if (w_u_hit) begin
                if (bus.update_taken && r_ctr[w_u_idx] != 2'b11) begin
                    r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'b01;
                end else if (!bus.update_taken &&
                             r_ctr[w_u_idx] != 2'b00) begin
                    r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'b01;
                end
            end else if (bus.update_taken) begin
                r_valid[w_u_idx] <= 1'b1;
                r_ctr[w_u_idx]   <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.flush && bus.update_en && bus.update_taken) begin
            r_target[w_u_idx] <= bus.update_target;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_pred_valid  <= 1'b0;
            r_pred_hit    <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else begin
            r_pred_valid <= bus.lookup_en;
            if (bus.lookup_en) begin
                r_pred_hit    <= w_l_hit;
                r_pred_taken  <= w_l_taken;
                r_pred_target <= w_l_next;
            end
        end
    end

    assign bus.pred_valid  = r_pred_valid;
    assign bus.pred_hit    = r_pred_hit;
    assign bus.pred_taken  = r_pred_taken;
    assign bus.pred_target = r_pred_target;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed vector bench for branch_target_predictor (INDEX_BITS=5, PC_W=64).
// Expected values are hand-computed; alias case depends on BTB_TAG_CHECK_EN.
module tb_branch_target_predictor;
    typedef struct {
        logic        le;
        logic [63:0] lpc;
        logic        ue;
        logic [63:0] upc;
        logic        ut;
        logic [63:0] utgt;
        logic        fl;
        logic        ev;
        logic        eh;
        logic        et;
        logic [63:0] etgt;
    } vec_t;

`ifdef BTB_TAG_CHECK_EN
    localparam bit ALIAS_HIT = 1'b0;
`else
    localparam bit ALIAS_HIT = 1'b1;
`endif

    logic clk;
    logic arst_n;
    int   n_cmp;
    int   n_bad;
    vec_t tv[$];

    branch_target_predictor_if #(.PC_W(64)) bus ();

    branch_target_predictor #(
        .INDEX_BITS(5),
        .PC_W(64)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(
        input logic le, input logic [63:0] lpc,
        input logic ue, input logic [63:0] upc,
        input logic ut, input logic [63:0] utgt, input logic fl,
        input logic ev, input logic eh, input logic et,
        input logic [63:0] etgt);
        vec_t v;
        v.le = le; v.lpc = lpc; v.ue = ue; v.upc = upc;
        v.ut = ut; v.utgt = utgt; v.fl = fl;
        v.ev = ev; v.eh = eh; v.et = et; v.etgt = etgt;
        tv.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev,
                             input logic eh, input logic et,
                             input logic [63:0] etgt);
        chk({tag, ".valid"}, 64'(bus.pred_valid), 64'(ev));
        chk({tag, ".hit"}, 64'(bus.pred_hit), 64'(eh));
        chk({tag, ".taken"}, 64'(bus.pred_taken), 64'(et));
        chk({tag, ".target"}, bus.pred_target, etgt);
    endtask

    task automatic drive(input vec_t v);
        bus.lookup_en     = v.le;
        bus.lookup_pc     = v.lpc;
        bus.update_en     = v.ue;
        bus.update_pc     = v.upc;
        bus.update_taken  = v.ut;
        bus.update_target = v.utgt;
        bus.flush         = v.fl;
    endtask

    task automatic idle();
        bus.lookup_en     = 1'b0;
        bus.lookup_pc     = '0;
        bus.update_en     = 1'b0;
        bus.update_pc     = '0;
        bus.update_taken  = 1'b0;
        bus.update_target = '0;
        bus.flush         = 1'b0;
    endtask

    task automatic apply(input string tag, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check_out(tag, v.ev, v.eh, v.et, v.etgt);
    endtask

    initial begin
        vec_t v;
        n_cmp  = 0;
        n_bad  = 0;
        arst_n = 1'b0;
        idle();

        // lookups, counter walk, saturation, target overwrite rules
        add(1, 64'h1000, 0, 0, 0, 0, 0, 1, 0, 0, 64'h1004);
        add(0, 0, 1, 64'h1000, 1, 64'h2000, 0, 0, 0, 0, 64'h1004);
        add(1, 64'h1000, 0, 0, 0, 0, 0, 1, 1, 1, 64'h2000);
        add(0, 0, 1, 64'h1000, 1, 64'h2000, 0, 0, 1, 1, 64'h2000);
        add(0, 0, 1, 64'h1000, 0, 64'h4444, 0, 0, 1, 1, 64'h2000);
        add(0, 0, 1, 64'h1000, 0, 64'h4444, 0, 0, 1, 1, 64'h2000);
        add(1, 64'h1000, 0, 0, 0, 0, 0, 1, 1, 0, 64'h1004);
        for (int i = 0; i < 4; i++)
            add(0, 0, 1, 64'h1000, 0, 0, 0, 0, 1, 0, 64'h1004);
        add(0, 0, 1, 64'h1000, 1, 64'h3000, 0, 0, 1, 0, 64'h1004);
        add(1, 64'h1000, 0, 0, 0, 0, 0, 1, 1, 0, 64'h1004);
        add(0, 0, 1, 64'h1000, 1, 64'h3000, 0, 0, 1, 0, 64'h1004);
        add(1, 64'h1000, 0, 0, 0, 0, 0, 1, 1, 1, 64'h3000);
        for (int i = 0; i < 4; i++)
            add(0, 0, 1, 64'h1000, 1, 64'h3000, 0, 0, 1, 1, 64'h3000);
        add(0, 0, 1, 64'h1000, 0, 64'h9999, 0, 0, 1, 1, 64'h3000);
        add(1, 64'h1000, 0, 0, 0, 0, 0, 1, 1, 1, 64'h3000);
        add(0, 0, 1, 64'h1000, 0, 64'h9999, 0, 0, 1, 1, 64'h3000);
        add(1, 64'h1000, 0, 0, 0, 0, 0, 1, 1, 0, 64'h1004);
        // alias: same index, different tag
        add(0, 0, 1, 64'h1000, 1, 64'h3000, 0, 0, 1, 0, 64'h1004);
        add(1, 64'h1080, 0, 0, 0, 0, 0, 1, ALIAS_HIT, ALIAS_HIT,
            ALIAS_HIT ? 64'h3000 : 64'h1084);
        // same-cycle allocate and lookup: read before write
        add(1, 64'h1008, 1, 64'h1008, 1, 64'h5000, 0, 1, 0, 0, 64'h100C);
        add(1, 64'h1008, 0, 0, 0, 0, 0, 1, 1, 1, 64'h5000);
        // next-PC wraps at the top of the address space
        add(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 1, 0, 0, 64'h0);
        // flush + update: flush wins; lookup sees pre-flush state
        add(1, 64'h1000, 1, 64'h1004, 1, 64'h6000, 1, 1, 1, 1, 64'h3000);
        add(1, 64'h1000, 0, 0, 0, 0, 0, 1, 0, 0, 64'h1004);
        add(1, 64'h1004, 0, 0, 0, 0, 0, 1, 0, 0, 64'h1008);
        add(1, 64'h1008, 0, 0, 0, 0, 0, 1, 0, 0, 64'h100C);

        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 0, 0, 0, 64'h0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tv.size(); i++) begin
            apply($sformatf("v%0d", i), tv[i]);
        end

        // async reset mid-update, then the entry must be gone
        v = tv[0];
        v.le = 0; v.ue = 1; v.upc = 64'h1008; v.ut = 1;
        v.utgt = 64'h7000; v.ev = 0; v.eh = 0; v.et = 0;
        v.etgt = 64'h100C;
        apply("alloc7", v);
        v.le = 1; v.lpc = 64'h1008; v.ue = 0;
        v.ev = 1; v.eh = 1; v.et = 1; v.etgt = 64'h7000;
        apply("hit7", v);
        v.ue = 1; v.ut = 0;
        drive(v);
        #3;
        arst_n = 1'b0;
        #1;
        check_out("arst", 0, 0, 0, 64'h0);
        @(posedge clk);
        #1;
        idle();
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_rst", 0, 0, 0, 64'h0);
        v.ue = 0; v.le = 1; v.lpc = 64'h1008;
        v.ev = 1; v.eh = 0; v.et = 0; v.etgt = 64'h100C;
        apply("miss7", v);

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch target buffer with per-entry 2-bit saturating direction counters, tags and full target addresses, sitting beside the fetch-stage PC register. Fetch issues a lookup each cycle and receives a registered taken/not-taken prediction plus next-fetch PC one cycle later. Execute writes back resolved branch outcomes through a separate update port. It replaces the earlier fixed 32-entry, untagged, untimed predictor.

## Interface

- `INDEX_BITS`, 5: log2 of entry count; depth = 2**INDEX_BITS.
- `PC_W`, 64: PC and target width.
- `clk` input 1: clock, all state on rising edge.
- `arst_n` input 1: asynchronous active-low reset.
- `lookup_en` input 1: lookup request this cycle.
- `lookup_pc` input PC_W: PC of the fetched instruction.
- `pred_valid` output 1: registered; 1 the cycle after a lookup_en.
- `pred_hit` output 1: registered; lookup matched a valid entry.
- `pred_taken` output 1: registered; hit and counter MSB = 1.
- `pred_target` output PC_W: registered; next-fetch PC.
- `update_en` input 1: resolved branch write-back.
- `update_pc` input PC_W: PC of the resolved branch.
- `update_taken` input 1: actual direction.
- `update_target` input PC_W: actual taken target.
- `flush` input 1: synchronous invalidate of all entries.

## Operation

- Index = pc[INDEX_BITS+1:2]; tag = pc[PC_W-1:INDEX_BITS+2]. PC bits [1:0] ignored.
- Entry fields: valid, tag, 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST), target.
- Lookup: hit = valid & tag match. pred_taken = hit & ctr[1]. pred_target = pred_taken ? entry target : lookup_pc + 4, truncated to PC_W bits (wraps).
- Update, hit: counter increments on taken and decrements on not-taken, saturating at 11/00. Target is overwritten only on taken.
- Update, miss, taken: allocate. Sets valid=1, writes tag and target, counter=10. Any existing entry is replaced.
- Update, miss, not-taken: no state change.
- flush: all valid bits cleared at the next edge. Counters, tags and targets are unchanged.

## Timing

- Lookup latency is 1 cycle. Outputs registered from the lookup_en cycle appear the following cycle.
- Cycles with lookup_en=0: pred_valid=0 next cycle. pred_hit, pred_taken and pred_target hold their previous values.
- Update takes effect at the edge ending the update_en cycle. A lookup to the same index in that same cycle sees pre-update state (read-before-write, no bypass).
- flush with update_en in the same cycle: flush wins and the update is dropped. flush with lookup_en: the lookup sees pre-flush state.
- Reset (asynchronous, any cycle including mid-update):
  - all valid bits = 0, all counters = 01
  - pred_valid = pred_hit = pred_taken = 0, pred_target = 0
  - tag and target contents are don't-care.
- After reset deassertion, the first lookup result is available one cycle after the first lookup_en.

## Configuration

- `BTB_TAG_CHECK_EN` defined: tag storage and comparison present, behaving as above.
- Not defined: no tag storage. hit = valid only, so aliased PCs sharing an index share the entry. A miss is then only an invalid entry. Update on a valid entry always counts as a hit.
- All ports are identical in both builds.

## Test plan

- Reset, then lookup 0x1000 -> next cycle: pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0x1004.
- Update 0x1000 taken/target 0x2000, then lookup 0x1000 -> hit=1, taken=1 (ctr 10), target=0x2000. A second taken update gives ctr=11. Two not-taken updates then give ctr=01 and a lookup returning taken=0, target=0x1004.
- Four not-taken updates on a hit entry -> ctr stays 00. Four taken updates -> ctr stays 11.
- With BTB_TAG_CHECK_EN and INDEX_BITS=5: allocate 0x1000 taken, then lookup 0x1080 (same index, different tag) -> hit=0. Without the macro -> hit=1, target of 0x1000.
- Same-cycle update (allocate) and lookup of 0x1000 -> lookup reports miss; the following lookup reports hit.
- Allocate 0x1000, then flush with a simultaneous taken update of 0x1004 -> both miss afterwards.
- Assert arst_n=0 mid-sequence -> all outputs 0 immediately; a prior entry misses after release.
